// File: rtl/microcode_sequencer.sv
// microcode_sequencer: fetches opcode bytes (with CB prefix page) and steps microcode addresses until retire, halt or error
module microcode_sequencer #(
  parameter int         OPCODE_TABLE_SIZE = 435,
  parameter int         MAX_STEPS         = 15,
  parameter logic [7:0] HALT_OPCODE       = 8'h76
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr_byte,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       uop_last,
  input  logic [8:0] uop_next,
  input  logic       stall,
  input  logic       irq_req,
  output logic [8:0] opcode,
  output logic       uop_valid,
  output logic       cb_active,
  output logic [3:0] step_count,
  output logic       instr_done,
  output logic       halted,
  output logic       seq_error
);
  typedef enum logic [1:0] {S_FETCH, S_PREFIX, S_EXEC, S_HALT} state_t;
  localparam logic [9:0] LP_TBL  = 10'(OPCODE_TABLE_SIZE);
  localparam logic [4:0] LP_MAX  = 5'(MAX_STEPS);
  localparam logic [8:0] LP_HALT = {1'b0, HALT_OPCODE};
  state_t     r_state, w_state_nxt;
  logic [8:0] r_opcode;
  logic [3:0] r_step;
  logic       r_done, r_err;
  logic       w_accept, w_load, w_adv, w_retire, w_bad, w_fault, w_step;
  always_comb begin
    w_accept = instr_valid && instr_ready;
    w_load   = w_accept && !(r_state == S_FETCH && instr_byte == 8'hCB);
    w_adv    = r_state == S_EXEC && !stall;
    w_retire = w_adv && uop_last;
    // the step limit is checked with >= so the counter can never wrap
    w_bad    = ({1'b0, uop_next} >= LP_TBL) || ({1'b0, r_step} >= LP_MAX);
    w_fault  = w_adv && !uop_last && w_bad;
    w_step   = w_adv && !uop_last && !w_bad;
  end
  always_ff @(posedge clk)
    r_state <= rst ? S_FETCH : w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  w_state_nxt = !w_accept ? S_FETCH : instr_byte == 8'hCB ? S_PREFIX : S_EXEC;
      S_PREFIX: w_state_nxt = w_accept ? S_EXEC : S_PREFIX;
      S_EXEC:   w_state_nxt = w_retire ? (r_opcode == LP_HALT ? S_HALT : S_FETCH) : w_fault ? S_FETCH : S_EXEC;
      S_HALT:   w_state_nxt = irq_req ? S_FETCH : S_HALT;
      default:  w_state_nxt = S_FETCH;
    endcase
  end
  always_comb begin
    instr_ready = r_state == S_FETCH || r_state == S_PREFIX;
    uop_valid   = r_state == S_EXEC;
    cb_active   = r_state == S_PREFIX;
    halted      = r_state == S_HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode <= '0;
      r_step   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_retire;
      r_err  <= r_err || w_fault;
      if (w_load) begin
        r_opcode <= {r_state == S_PREFIX, instr_byte};
        r_step   <= '0;
      end else if (w_step) begin
        r_opcode <= uop_next;
        r_step   <= r_step + 4'd1;
      end
    end
  end
  assign opcode     = r_opcode;
  assign step_count = r_step;
  assign instr_done = r_done;
  assign seq_error  = r_err;
endmodule
